usb_host_txn: RTL and testbench
===============================

# usb_host_txn

Host-side transaction controller sitting in front of the USB transmit pipeline (CRC encoder → bit stuffer → NRZI → DP/DM driver). It accepts one OUT or IN transaction request at a time and sequences the packets it needs through the encoder's 99-bit packet handshake. It collects the device response from the receive path and manages data toggles, timeouts and retries. It then reports a single completion status per request.

## Interface
- TIMEOUT, 255: cycles to wait for a device response after the last transmitted packet completes.
- MAX_RETRY, 8: failed attempts (NAK, timeout, toggle mismatch) before the request completes as FAIL.
- clk  in  1  system clock; all state on its rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present; req_* fields stable while high.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid && req_ready.
- req_dir  in  1  0 = OUT (host→device), 1 = IN.
- req_addr  in  7  device address.
- req_endp  in  4  endpoint number.
- req_data  in  64  OUT payload.
- pkt  out  99  packet to encoder; layout under Operation.
- pkt_avail  out  1  pkt valid; held with pkt stable until accepted.
- enc_ready  in  1  encoder can accept; transfer on pkt_avail && enc_ready.
- tx_done  in  1  one-cycle pulse when the line has returned to idle after the packet.
- rx_valid  in  1  one-cycle pulse: received packet decoded.
- rx_pid  in  4  received PID.
- rx_data  in  64  received payload; valid with rx_valid.
- rx_crc_ok  in  1  received CRC good; valid with rx_valid.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 OK, 01 FAIL, 10 STALL; valid with done, held until the next done.
- resp_data  out  64  IN payload; updated only on an OK IN completion.

## Operation
- PIDs: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
- pkt layout: [98:91] SYNC 8'b0000_0001; [90:83] {~pid, pid}. The remaining field depends on packet type:
  - Token: [82:72] {addr, endp}.
  - Data: [82:19] payload.
- All unused bits, including the CRC field, are 0; the encoder inserts the CRC.
- States: IDLE, TOKEN, TOKEN_WAIT, DATA, DATA_WAIT, WAIT_HS, WAIT_DATA, ACK, ACK_WAIT, DONE.
- IDLE → TOKEN on accept: latch the request and clear the retry count.
- TOKEN: drive the token with pkt_avail. Advance to TOKEN_WAIT on transfer.
- TOKEN_WAIT: on tx_done, go to DATA (OUT) or WAIT_DATA (IN).
- DATA / DATA_WAIT: send DATA0/DATA1 per tog_out, then go to WAIT_HS on tx_done.
- WAIT_HS, only rx_valid with rx_crc_ok counts:
  - ACK: toggle tog_out, go to DONE with OK.
  - NAK, timeout, or any other PID: retry.
  - STALL: go to DONE with STALL.
- WAIT_DATA, rx_valid with bad CRC is ignored and waiting continues:
  - DATAx matching tog_in: latch rx_data, toggle tog_in, go to ACK.
  - DATAx mismatching tog_in: go to ACK, discard the data, then retry.
  - NAK or timeout: retry.
  - STALL: go to DONE with STALL.
- ACK / ACK_WAIT: send the ACK handshake. On tx_done, go to DONE with OK, or retry on a mismatch.
- Retry: increment the retry count. If count == MAX_RETRY, go to DONE with FAIL; otherwise go to TOKEN.
- DONE: pulse done for one cycle, then go to IDLE.
- tog_out/tog_in are single controller-wide bits, 0 after reset.

## Timing
- Reset values: req_ready 1, pkt 0, pkt_avail 0, done 0, status 00, resp_data 0, toggles 0, state IDLE.
- Asserting rst_b low mid-transaction aborts immediately; pkt_avail drops asynchronously.
- Accept cycle N → pkt_avail high at N+1.
- pkt_avail stays high until enc_ready; pkt is never changed while pkt_avail is high.
- Timeout counter clears on entering WAIT_HS/WAIT_DATA and increments every cycle. Timeout fires when the counter equals TIMEOUT with no qualifying rx_valid.
- rx_valid in the same cycle as the timeout: rx_valid wins.
- rx_valid and tx_done outside the wait states are ignored.
- done is asserted the cycle after the terminal event; req_ready returns the cycle after done.

## Structure
- Package usb_pkg holds:
  - PID enum;
  - SYNC constant;
  - pkt field-offset localparams;
  - status enum;
  - state enum;
  - function build_pkt(pid, addr, endp, data) returning the 99-bit vector.
- One sub-module, usb_txn_timer: loadable cycle counter with clear, enable and an expired output, parameterized by TIMEOUT.

## Test plan
- OUT, ACK at first try: addr 7'h05, endp 4'h1, data 64'hDEADBEEF_01234567.
  - Sent: token pkt[90:83]=8'hE1, pkt[82:72]=11'h051; then DATA0.
  - Response: done with status 00; tog_out becomes 1.
- IN, DATA0 received with crc ok, data 64'hA5A5...:
  - ACK is sent (pkt[90:83]=8'hD2).
  - resp_data = 64'hA5A5...; status 00; tog_in becomes 1.
- OUT, device NAKs every attempt: exactly 8 tokens are sent, then status 01.
- IN, no response: WAIT_DATA persists TIMEOUT cycles, then a retry token is sent.
  - A bad-CRC rx_valid during the wait does not reset or shorten the timeout.
- OUT, STALL response: done with status 10; tog_out unchanged.
- Stall enc_ready low 20 cycles during TOKEN:
  - pkt/pkt_avail stay stable throughout.
  - rst_b low mid-DATA_WAIT returns all outputs to reset values immediately.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and packet formatting for the USB host transaction controller.
// Packets are 99-bit frames handed to the CRC encoder with the CRC field left zero.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_FAIL  = 2'b01,
        ST_STALL = 2'b10
    } status_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOKEN,
        S_TOKEN_WAIT,
        S_DATA,
        S_DATA_WAIT,
        S_WAIT_HS,
        S_WAIT_DATA,
        S_ACK,
        S_ACK_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] SYNC     = 8'b0000_0001;
    localparam int         PKT_W    = 99;
    localparam int         SYNC_LSB = 91;
    localparam int         PID_LSB  = 83;
    localparam int         TOK_LSB  = 72;
    localparam int         DATA_LSB = 19;

    // The PID decides which body field is populated; handshakes carry none.
    function automatic logic [PKT_W-1:0] build_pkt(input logic [3:0]  pid,
                                                   input logic [6:0]  addr,
                                                   input logic [3:0]  endp,
                                                   input logic [63:0] data);
        logic [PKT_W-1:0] p;
        p = '0;
        p[SYNC_LSB +: 8] = SYNC;
        p[PID_LSB +: 8]  = {~pid, pid};
        case (pid)
            PID_OUT, PID_IN:      p[TOK_LSB +: 11]  = {addr, endp};
            PID_DATA0, PID_DATA1: p[DATA_LSB +: 64] = data;
            default:              ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/usb_txn_timer.sv
// Response timer: counts while enabled, clears or loads on demand, and flags
// the cycle in which the count equals TIMEOUT.
module usb_txn_timer #(
    parameter int TIMEOUT = 255,
    localparam int W = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == W'(TIMEOUT));

endmodule

// File: rtl/usb_host_txn.sv
// Host transaction controller: sequences token/data/handshake packets for one
// OUT or IN request, tracks data toggles and retries, and reports one status.
module usb_host_txn
    import usb_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_dir,
    input  logic [6:0]  req_addr,
    input  logic [3:0]  req_endp,
    input  logic [63:0] req_data,
    output logic [98:0] pkt,
    output logic        pkt_avail,
    input  logic        enc_ready,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_data,
    input  logic        rx_crc_ok,
    output logic        done,
    output logic [1:0]  status,
    output logic [63:0] resp_data,
    output logic [3:0]  dbg_state
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    // Handshake: a packet moves to the encoder on pkt_avail && enc_ready, and
    // pkt is frozen for as long as pkt_avail is high.
    state_t         state_q, state_d;
    status_t        status_q, status_d;
    logic           dir_q, dir_d;
    logic [6:0]     addr_q, addr_d;
    logic [3:0]     endp_q, endp_d;
    logic [63:0]    data_q, data_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           tog_out_q, tog_out_d;
    logic           tog_in_q, tog_in_d;
    logic           mis_q, mis_d;
    logic [63:0]    buf_q, buf_d;
    logic [63:0]    resp_q, resp_d;
    logic [98:0]    pkt_q, pkt_d;
    logic           avail_q, avail_d;

    logic           expired;
    logic           tmr_clr;
    logic           tmr_en;
    logic           do_retry;
    logic           rx_good;
    logic [RW-1:0]  retry_inc;
    pid_t           in_pid;
    pid_t           tok_pid;

    assign rx_good   = rx_valid && rx_crc_ok;
    assign retry_inc = retry_q + 1'b1;
    assign in_pid    = tog_in_q ? PID_DATA1 : PID_DATA0;
    // On the accept cycle the request fields are not yet latched.
    assign tok_pid   = ((state_q == S_IDLE) ? req_dir : dir_q) ? PID_IN : PID_OUT;

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        data_d    = data_q;
        retry_d   = retry_q;
        tog_out_d = tog_out_q;
        tog_in_d  = tog_in_q;
        mis_d     = mis_q;
        buf_d     = buf_q;
        resp_d    = resp_q;
        pkt_d     = pkt_q;
        do_retry  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_TOKEN;
                    dir_d   = req_dir;
                    addr_d  = req_addr;
                    endp_d  = req_endp;
                    data_d  = req_data;
                    retry_d = '0;
                end
            end
            S_TOKEN:      if (enc_ready) state_d = S_TOKEN_WAIT;
            S_TOKEN_WAIT: if (tx_done)   state_d = dir_q ? S_WAIT_DATA : S_DATA;
            S_DATA:       if (enc_ready) state_d = S_DATA_WAIT;
            S_DATA_WAIT:  if (tx_done)   state_d = S_WAIT_HS;
            S_WAIT_HS: begin
                if (rx_good) begin
                    if (rx_pid == PID_ACK) begin
                        tog_out_d = ~tog_out_q;
                        status_d  = ST_OK;
                        state_d   = S_DONE;
                    end else if (rx_pid == PID_STALL) begin
                        status_d = ST_STALL;
                        state_d  = S_DONE;
                    end else begin
                        do_retry = 1'b1;
                    end
                end else if (expired) begin
                    do_retry = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                // Bad-CRC packets fall through so the timer keeps running.
                if (rx_good && (rx_pid == PID_DATA0 || rx_pid == PID_DATA1)) begin
                    state_d = S_ACK;
                    mis_d   = (rx_pid != in_pid);
                    if (rx_pid == in_pid) begin
                        buf_d    = rx_data;
                        tog_in_d = ~tog_in_q;
                    end
                end else if (rx_good && rx_pid == PID_STALL) begin
                    status_d = ST_STALL;
                    state_d  = S_DONE;
                end else if ((rx_good && rx_pid == PID_NAK) || expired) begin
                    do_retry = 1'b1;
                end
            end
            S_ACK:        if (enc_ready) state_d = S_ACK_WAIT;
            S_ACK_WAIT: begin
                if (tx_done) begin
                    if (mis_q) begin
                        do_retry = 1'b1;
                    end else begin
                        status_d = ST_OK;
                        resp_d   = buf_q;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase

        if (do_retry) begin
            retry_d = retry_inc;
            if (retry_inc == RW'(MAX_RETRY)) begin
                status_d = ST_FAIL;
                state_d  = S_DONE;
            end else begin
                state_d = S_TOKEN;
            end
        end

        // Packets are formatted only on entry, so pkt never moves while offered.
        if (state_d != state_q) begin
            case (state_d)
                S_TOKEN: pkt_d = build_pkt(tok_pid,
                                           (state_q == S_IDLE) ? req_addr : addr_q,
                                           (state_q == S_IDLE) ? req_endp : endp_q,
                                           64'd0);
                S_DATA:  pkt_d = build_pkt(tog_out_q ? PID_DATA1 : PID_DATA0,
                                           addr_q, endp_q, data_q);
                S_ACK:   pkt_d = build_pkt(PID_ACK, addr_q, endp_q, 64'd0);
                default: ;
            endcase
        end
        avail_d = (state_d == S_TOKEN) || (state_d == S_DATA) || (state_d == S_ACK);
    end

    assign tmr_clr = (state_d != state_q) &&
                     (state_d == S_WAIT_HS || state_d == S_WAIT_DATA);
    assign tmr_en  = (state_q == S_WAIT_HS) || (state_q == S_WAIT_DATA);

    usb_txn_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk        (clk),
        .rst_b      (rst_b),
        .clr_i      (tmr_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (tmr_en),
        .expired_o  (expired)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            status_q  <= ST_OK;
            dir_q     <= 1'b0;
            addr_q    <= '0;
            endp_q    <= '0;
            data_q    <= '0;
            retry_q   <= '0;
            tog_out_q <= 1'b0;
            tog_in_q  <= 1'b0;
            mis_q     <= 1'b0;
            buf_q     <= '0;
            resp_q    <= '0;
            pkt_q     <= '0;
            avail_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            endp_q    <= endp_d;
            data_q    <= data_d;
            retry_q   <= retry_d;
            tog_out_q <= tog_out_d;
            tog_in_q  <= tog_in_d;
            mis_q     <= mis_d;
            buf_q     <= buf_d;
            resp_q    <= resp_d;
            pkt_q     <= pkt_d;
            avail_q   <= avail_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign status    = status_q;
    assign resp_data = resp_q;
    assign pkt       = pkt_q;
    assign pkt_avail = avail_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_usb_host_txn.sv
// Directed-plus-random bench for usb_host_txn: a transaction-level model tracks
// toggles, expected packets and completion status.
module tb_usb_host_txn;

    localparam int TIMEOUT   = 255;
    localparam int MAX_RETRY = 8;

    localparam logic [3:0] P_OUT   = 4'b0001;
    localparam logic [3:0] P_IN    = 4'b1001;
    localparam logic [3:0] P_D0    = 4'b0011;
    localparam logic [3:0] P_D1    = 4'b1011;
    localparam logic [3:0] P_ACK   = 4'b0010;
    localparam logic [3:0] P_NAK   = 4'b1010;
    localparam logic [3:0] P_STALL = 4'b1110;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_dir = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [3:0]  req_endp = '0;
    logic [63:0] req_data = '0;
    logic [98:0] pkt;
    logic        pkt_avail;
    logic        enc_ready = 1'b0;
    logic        tx_done = 1'b0;
    logic        rx_valid = 1'b0;
    logic [3:0]  rx_pid = '0;
    logic [63:0] rx_data = '0;
    logic        rx_crc_ok = 1'b0;
    logic        done;
    logic [1:0]  status;
    logic [63:0] resp_data;
    logic [3:0]  dbg_state;

    usb_host_txn #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dir   (req_dir),
        .req_addr  (req_addr),
        .req_endp  (req_endp),
        .req_data  (req_data),
        .pkt       (pkt),
        .pkt_avail (pkt_avail),
        .enc_ready (enc_ready),
        .tx_done   (tx_done),
        .rx_valid  (rx_valid),
        .rx_pid    (rx_pid),
        .rx_data   (rx_data),
        .rx_crc_ok (rx_crc_ok),
        .done      (done),
        .status    (status),
        .resp_data (resp_data),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model state / scoreboard ----------------
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        m_tog_out = 1'b0;
    logic        m_tog_in  = 1'b0;
    logic [63:0] m_resp    = '0;
    logic [98:0] exp_q[$];

    function automatic logic [98:0] exp_pkt(input logic [3:0] pid, input logic [6:0] a,
                                            input logic [3:0] e, input logic [63:0] d);
        case (pid)
            P_OUT, P_IN: return {8'h01, ~pid, pid, a, e, 72'd0};
            P_D0, P_D1:  return {8'h01, ~pid, pid, d, 19'd0};
            default:     return {8'h01, ~pid, pid, 83'd0};
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic dir, input logic [6:0] a, input logic [3:0] e,
                            input logic [63:0] d);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin tick; n++; end
        check("req_ready before accept", req_ready, 1);
        req_dir = dir; req_addr = a; req_endp = e; req_data = d;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        check("accept latency pkt_avail", pkt_avail, 1);
        check("req_ready after accept", req_ready, 0);
    endtask

    task automatic xfer_pkt(input string tag);
        logic [98:0] exp;
        int n;
        exp = exp_q.pop_front();
        n = 0;
        while (pkt_avail !== 1'b1 && n < 50) begin tick; n++; end
        check({tag, " avail"}, pkt_avail, 1);
        check({tag, " pkt"}, pkt, exp);
        repeat ($urandom_range(0, 3)) begin
            tick;
            check({tag, " held"}, {pkt_avail, pkt}, {1'b1, exp});
        end
        enc_ready = 1'b1;
        tick;
        enc_ready = 1'b0;
        check({tag, " avail drop"}, pkt_avail, 0);
        repeat ($urandom_range(1, 4)) tick;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    task automatic send_rx(input logic [3:0] pid, input logic [63:0] d, input logic crc);
        repeat ($urandom_range(0, 4)) tick;
        rx_pid = pid; rx_data = d; rx_crc_ok = crc;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        rx_crc_ok = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp_status);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick; n++; end
        check({tag, " done"}, done, 1);
        check({tag, " status"}, status, exp_status);
        check({tag, " resp_data"}, resp_data, m_resp);
        tick;
        check({tag, " done pulse"}, done, 0);
        check({tag, " req_ready back"}, req_ready, 1);
    endtask

    // n_bad failed attempts (NAK or toggle mismatch) before a successful one.
    task automatic run_txn(input string tag, input logic dir, input logic [6:0] a,
                           input logic [3:0] e, input logic [63:0] d, input int n_bad);
        logic [63:0] rd;
        send_req(dir, a, e, d);
        for (int att = 0; att <= n_bad; att++) begin
            exp_q.push_back(exp_pkt(dir ? P_IN : P_OUT, a, e, 64'd0));
            xfer_pkt({tag, " token"});
            if (!dir) begin
                exp_q.push_back(exp_pkt(m_tog_out ? P_D1 : P_D0, a, e, d));
                xfer_pkt({tag, " data"});
                if (att < n_bad) begin
                    send_rx(P_NAK, 64'd0, 1'b1);
                end else begin
                    send_rx(P_ACK, 64'd0, 1'b1);
                    m_tog_out = ~m_tog_out;
                end
            end else if (att < n_bad && $urandom_range(0, 1) == 0) begin
                send_rx(P_NAK, 64'd0, 1'b1);
            end else if (att < n_bad) begin
                send_rx(m_tog_in ? P_D0 : P_D1, {$urandom(), $urandom()}, 1'b1);
                exp_q.push_back(exp_pkt(P_ACK, a, e, 64'd0));
                xfer_pkt({tag, " mismatch ack"});
            end else begin
                rd = {$urandom(), $urandom()};
                send_rx(m_tog_in ? P_D1 : P_D0, rd, 1'b1);
                m_tog_in = ~m_tog_in;
                m_resp   = rd;
                exp_q.push_back(exp_pkt(P_ACK, a, e, 64'd0));
                xfer_pkt({tag, " ack"});
            end
        end
        wait_done(tag, 2'b00);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [98:0] tok;
        int          cyc;
        logic [6:0]  a;
        logic [3:0]  e;

        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", req_ready, 1);
        check("reset pkt", pkt, 0);
        check("reset pkt_avail", pkt_avail, 0);
        check("reset done", done, 0);
        check("reset status", status, 0);
        check("reset resp_data", resp_data, 0);
        check("reset dbg_state known", (^dbg_state) !== 1'bx, 1);
        rst_b = 1'b1;
        tick;

        // OUT acknowledged on the first attempt
        send_req(1'b0, 7'h05, 4'h1, 64'hDEADBEEF_01234567);
        check("out1 token pid", pkt[90:83], 8'hE1);
        check("out1 token addr/endp", pkt[82:72], 11'h051);
        exp_q.push_back(exp_pkt(P_OUT, 7'h05, 4'h1, 64'd0));
        xfer_pkt("out1 token");
        exp_q.push_back(exp_pkt(P_D0, 7'h05, 4'h1, 64'hDEADBEEF_01234567));
        xfer_pkt("out1 data0");
        send_rx(P_ACK, 64'd0, 1'b1);
        m_tog_out = 1'b1;
        wait_done("out1", 2'b00);

        // IN returning DATA0
        send_req(1'b1, 7'h22, 4'h2, 64'd0);
        exp_q.push_back(exp_pkt(P_IN, 7'h22, 4'h2, 64'd0));
        xfer_pkt("in1 token");
        send_rx(P_D0, 64'hA5A5A5A5_A5A5A5A5, 1'b1);
        m_tog_in = 1'b1;
        m_resp   = 64'hA5A5A5A5_A5A5A5A5;
        check("in1 ack pid", pkt[90:83], 8'hD2);
        exp_q.push_back(exp_pkt(P_ACK, 7'h22, 4'h2, 64'd0));
        xfer_pkt("in1 ack");
        wait_done("in1", 2'b00);

        // Randomized transactions with a few failed attempts each
        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                    7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)),
                    {$urandom(), $urandom()}, $urandom_range(0, 2));
        end

        // OUT NAKed on every attempt: MAX_RETRY tokens then FAIL
        a = 7'h12; e = 4'h3;
        send_req(1'b0, a, e, 64'h0123_4567_89AB_CDEF);
        for (int att = 0; att < MAX_RETRY; att++) begin
            exp_q.push_back(exp_pkt(P_OUT, a, e, 64'd0));
            xfer_pkt($sformatf("nak token%0d", att));
            exp_q.push_back(exp_pkt(m_tog_out ? P_D1 : P_D0, a, e, 64'h0123_4567_89AB_CDEF));
            xfer_pkt($sformatf("nak data%0d", att));
            send_rx(P_NAK, 64'd0, 1'b1);
        end
        check("nak no extra token", pkt_avail, 0);
        wait_done("nak fail", 2'b01);

        // IN with no response: timeout then retry; bad-CRC packet ignored
        a = 7'h3C; e = 4'h7;
        send_req(1'b1, a, e, 64'd0);
        exp_q.push_back(exp_pkt(P_IN, a, e, 64'd0));
        xfer_pkt("tmo token");
        cyc = 0;
        while (pkt_avail !== 1'b1 && cyc < TIMEOUT + 50) begin
            rx_valid  = (cyc == 100);
            rx_pid    = m_tog_in ? P_D1 : P_D0;
            rx_data   = 64'hBAD0_BAD0_BAD0_BAD0;
            rx_crc_ok = 1'b0;
            tick;
            cyc++;
        end
        rx_valid = 1'b0;
        check("tmo cycles to retry", cyc, TIMEOUT + 1);
        exp_q.push_back(exp_pkt(P_IN, a, e, 64'd0));
        xfer_pkt("tmo retry token");
        send_rx(m_tog_in ? P_D1 : P_D0, 64'h1122_3344_5566_7788, 1'b1);
        m_tog_in = ~m_tog_in;
        m_resp   = 64'h1122_3344_5566_7788;
        exp_q.push_back(exp_pkt(P_ACK, a, e, 64'd0));
        xfer_pkt("tmo ack");
        wait_done("tmo", 2'b00);

        // OUT answered with STALL; toggle must not move
        a = 7'h41; e = 4'hE;
        send_req(1'b0, a, e, 64'hFEED_FACE_CAFE_F00D);
        exp_q.push_back(exp_pkt(P_OUT, a, e, 64'd0));
        xfer_pkt("stall token");
        exp_q.push_back(exp_pkt(m_tog_out ? P_D1 : P_D0, a, e, 64'hFEED_FACE_CAFE_F00D));
        xfer_pkt("stall data");
        send_rx(P_STALL, 64'd0, 1'b1);
        wait_done("stall", 2'b10);
        run_txn("after stall", 1'b0, 7'h41, 4'hE, 64'h5555_AAAA_5555_AAAA, 0);

        // Encoder back-pressure on the token, then reset during DATA_WAIT
        a = 7'h7F; e = 4'hF;
        send_req(1'b0, a, e, 64'h0F0F_0F0F_0F0F_0F0F);
        tok = exp_pkt(P_OUT, a, e, 64'd0);
        for (int i = 0; i < 20; i++) begin
            check("backpressure held", {pkt_avail, pkt}, {1'b1, tok});
            tick;
        end
        exp_q.push_back(tok);
        xfer_pkt("bp token");
        cyc = 0;
        while (pkt_avail !== 1'b1 && cyc < 50) begin tick; cyc++; end
        check("bp data pkt", pkt, exp_pkt(m_tog_out ? P_D1 : P_D0, a, e, 64'h0F0F_0F0F_0F0F_0F0F));
        enc_ready = 1'b1;
        tick;
        enc_ready = 1'b0;
        tick;
        #2;
        rst_b = 1'b0;
        #1;
        check("async reset req_ready", req_ready, 1);
        check("async reset pkt", pkt, 0);
        check("async reset pkt_avail", pkt_avail, 0);
        check("async reset done", done, 0);
        check("async reset status", status, 0);
        check("async reset resp_data", resp_data, 0);
        m_tog_out = 1'b0;
        m_tog_in  = 1'b0;
        m_resp    = '0;
        #3;
        rst_b = 1'b1;
        tick;

        // Toggles restart from DATA0 after reset
        run_txn("post reset out", 1'b0, 7'h09, 4'h4, 64'hC0DE_C0DE_C0DE_C0DE, 0);
        run_txn("post reset in", 1'b1, 7'h0A, 4'h5, 64'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
